// File: rtl/hazard_pkg.sv
// Shared hazard-unit encodings and the operand forwarding compare.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package hazard_pkg;

  localparam int REG_W_DEFAULT = 5;

  // ALU operand source selects
  localparam logic [1:0] FWD_RD  = 2'b00;  // register-file read data from decode
  localparam logic [1:0] FWD_WB  = 2'b01;  // ResultW from writeback
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALUResultM from memory

  // ResultSrcE value that marks a load in execute
  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  // Pick the operand source for one execute source register.
  // Addresses arrive zero-extended to 32 bits so any REG_W fits.
  // The memory stage holds the younger result, so it is checked first.
  // x0 is hard-wired to zero and is never forwarded.
  function automatic logic [1:0] fwd_select(
    input logic        wr_m,
    input logic [31:0] rd_m,
    input logic        wr_w,
    input logic [31:0] rd_w,
    input logic [31:0] rs
  );
    if (wr_m && (rd_m != 32'd0) && (rd_m == rs)) begin
      return FWD_MEM;
    end else if (wr_w && (rd_w != 32'd0) && (rd_w == rs)) begin
      return FWD_WB;
    end else begin
      return FWD_RD;
    end
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Pipeline <-> hazard unit signal bundle: register fields in, selects/stalls/flushes out.
// Latency: n/a (wires only).
// Backpressure: none; stall/flush lines are the pipeline's only throttle.
interface hazard_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] Rs1D;
  logic [REG_W-1:0] Rs2D;
  logic [REG_W-1:0] Rs1E;
  logic [REG_W-1:0] Rs2E;
  logic [REG_W-1:0] RdE;
  logic             RegWriteE;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;

  // Pipeline datapath side
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
  );

  // Hazard unit side
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
  );
endinterface

// File: rtl/hazard_dest_pipe.sv
// Shadow copy of destination register / write enable for the memory and writeback stages.
// Latency: one cycle per stage (execute -> memory -> writeback).
// Backpressure: none; never stalls, bubbles arrive as wr_e=0.
module hazard_dest_pipe #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rd_e,
  input  logic             wr_e,
  output logic [REG_W-1:0] rd_m,
  output logic             wr_m,
  output logic [REG_W-1:0] rd_w,
  output logic             wr_w
);

  // Advance the destination tags one stage per clock; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_m <= '0;
      wr_m <= 1'b0;
      rd_w <= '0;
      wr_w <= 1'b0;
    end else begin
      rd_m <= rd_e;
      wr_m <= wr_e;
      rd_w <= rd_m;
      wr_w <= wr_m;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Forwarding selects, load-use stall and branch flush control, plus stall/flush counters.
// Latency: outputs combinational (zero cycle); tracked state and counters update next clock.
// Backpressure: none received; StallF/StallD/FlushD/FlushE are the backpressure it applies.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  hazard_if.slave          hif,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [REG_W-1:0] rd_e;
  logic [REG_W-1:0] rd_m;
  logic [REG_W-1:0] rd_w;
  logic             wr_m;
  logic             wr_w;
  logic             lw_stall;
  logic             stall_d;

  assign rd_e = hif.RdE;

  hazard_dest_pipe #(
    .REG_W (REG_W)
  ) u_dest_pipe (
    .clk   (clk),
    .reset (reset),
    .rd_e  (rd_e),
    .wr_e  (hif.RegWriteE),
    .rd_m  (rd_m),
    .wr_m  (wr_m),
    .rd_w  (rd_w),
    .wr_w  (wr_w)
  );

  // A load in execute whose destination is read by the instruction in decode
  assign lw_stall = (hif.ResultSrcE == RESULTSRC_LOAD) && (rd_e != '0) &&
                    ((rd_e == hif.Rs1D) || (rd_e == hif.Rs2D));

  // A taken branch squashes the stall: the dependent instruction is being flushed anyway
  assign stall_d = lw_stall && !hif.PCSrcE && !reset;

  // Operand selects and pipeline control; reset forces a clean, flushed pipeline
  always_comb begin
    hif.ForwardAE = FWD_RD;
    hif.ForwardBE = FWD_RD;
    hif.StallF    = 1'b0;
    hif.StallD    = 1'b0;
    hif.FlushD    = 1'b1;
    hif.FlushE    = 1'b1;
    if (!reset) begin
      hif.ForwardAE = fwd_select(wr_m, 32'(rd_m), wr_w, 32'(rd_w), 32'(hif.Rs1E));
      hif.ForwardBE = fwd_select(wr_m, 32'(rd_m), wr_w, 32'(rd_w), 32'(hif.Rs2E));
      hif.StallF    = stall_d;
      hif.StallD    = stall_d;
      hif.FlushD    = hif.PCSrcE;
      hif.FlushE    = lw_stall || hif.PCSrcE;
    end
  end

  // Count stalled decode cycles and branch flushes, wrapping naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_d) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (hif.PCSrcE) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumer and controller at the far side of the decode→execute stage register in the 5-stage RISC-V pipeline.
- Takes the execute-stage register fields (Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE) plus decode-stage source registers and the execute branch decision.
- Drives ALU operand forwarding selects and the stall/flush controls for fetch, decode and execute.
- Keeps its own registered copy of destination/write-enable for the memory and writeback stages, and exposes performance counters.

Parameters:
- REG_W, 5, register-address width
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- Rs1D  in  REG_W  decode source 1
- Rs2D  in  REG_W  decode source 2
- Rs1E  in  REG_W  execute source 1
- Rs2E  in  REG_W  execute source 2
- RdE  in  REG_W  execute destination
- RegWriteE  in  1  execute instruction writes the register file
- ResultSrcE  in  2  execute result select; 2'b01 = load
- PCSrcE  in  1  branch/jump taken in execute
- ForwardAE  out  2  operand A select: 00 rd1E, 10 ALUResultM, 01 ResultW
- ForwardBE  out  2  operand B select, same encoding
- StallF  out  1  hold PC
- StallD  out  1  hold decode register
- FlushD  out  1  clear decode register
- FlushE  out  1  clear execute register (drives its reset input)
- stall_count  out  CNT_W  cycles with StallD=1
- flush_count  out  CNT_W  cycles with PCSrcE-caused flush

Behaviour:
- Internal state:
  - Registers RdM, RegWriteM, RdW, RegWriteW.
  - Every posedge when reset=0: RdM<=RdE, RegWriteM<=RegWriteE, RdW<=RdM, RegWriteW<=RegWriteM.
  - These registers never stall. Execute is never stalled; a bubble arriving via FlushE appears as RegWriteE=0.
- Reset (reset=1 at posedge): RdM, RdW, RegWriteM, RegWriteW and both counters cleared to 0.
- Outputs while reset=1 (combinational override):
  - ForwardAE=ForwardBE=00, StallF=StallD=0, FlushD=FlushE=1.
- Forwarding, evaluated for each operand independently (shown for A):
  - RegWriteM && RdM!=0 && RdM==Rs1E → 10.
  - Otherwise RegWriteW && RdW!=0 && RdW==Rs1E → 01.
  - Otherwise → 00.
  - Memory stage has priority over writeback. x0 is never forwarded.
- Load-use: lwStall = (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- Control outputs:
  - StallF = StallD = lwStall && !PCSrcE.
  - FlushD = PCSrcE.
  - FlushE = lwStall || PCSrcE.
  - PCSrcE wins over a simultaneous lwStall: no stall, both flushes asserted.
- Latency: all outputs are combinational from the inputs and internal state (zero cycle). State updates take one cycle.
- Counters:
  - stall_count increments on each clock with StallD=1.
  - flush_count increments on each clock with PCSrcE=1.
  - Both wrap modulo 2^CNT_W.
  - Neither increments during the reset cycle.
- Reset asserted mid-stream discards tracked RdM/RdW. The first cycle after reset produces no forwarding.

Decomposition:
- Shared package hazard_pkg holds:
  - forwarding encodings FWD_RD=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - RESULTSRC_LOAD=2'b01;
  - REG_W default.
- One sub-module, hazard_dest_pipe: the two-stage Rd/RegWrite shift register with synchronous reset.
- Forwarding compare: one function in the package, used for both operands.

Test Plan:
- Back-to-back ALU ops:
  - Cycle 0: RdE=5, RegWriteE=1.
  - Cycle 1: Rs1E=5 → ForwardAE=10.
  - Cycle 2: Rs2E=5 with no new write → ForwardBE=01.
- x0 and priority:
  - RdE=0 with RegWriteE=1, then Rs1E=0 → ForwardAE=00.
  - Writes to r7 on two consecutive cycles, then Rs1E=7 → ForwardAE=10 (memory beats writeback).
- Load-use: ResultSrcE=01, RdE=3, Rs2D=3 → StallF=StallD=FlushE=1, FlushD=0, stall_count +1.
  - Next cycle, with bubble RegWriteE=0 → no stall.
- Taken branch: PCSrcE=1 → FlushD=FlushE=1, stalls 0, flush_count +1.
  - Repeat with lwStall conditions also true → StallF=0, both flushes 1.
- Reset mid-stream:
  - Assert reset for 1 cycle with RegWriteM tracking r4 → outputs Forward=00, FlushD=FlushE=1, counters 0.
  - After release, Rs1E=4 → ForwardAE=00.
- Counter wrap (CNT_W=4): 16 consecutive stall cycles → stall_count returns to 0.
